// File: rtl/sc_pkg.sv
// sc_pkg: shared constants, state type and helpers for the stochastic-computing datapath
package sc_pkg;
  localparam int SC_N = 12;
  localparam int SC_POW2N = 4096;
  localparam logic [SC_N-1:0] SC_TAPS = 12'hE08;
  typedef enum logic {IDLE, RUN} sc_gen_state_t;
  function automatic logic [SC_N:0] sat_prob(input logic [SC_N:0] p);
    return (p > (SC_N+1)'(SC_POW2N)) ? (SC_N+1)'(SC_POW2N) : p;
  endfunction
endpackage

// File: rtl/sc_debruijn_lfsr.sv
// sc_debruijn_lfsr: zero-inserting Fibonacci LFSR visiting all 2^N states per period
module sc_debruijn_lfsr import sc_pkg::*; #(
  parameter int N = SC_N,
  parameter logic [N-1:0] TAPS = SC_TAPS,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         advance,
  output logic [N-1:0] r
);
  logic [N-1:0] r_q, r_d;
  logic fb;
  // Feedback with the NOR term splices the all-zero state into the maximal cycle
  always_comb begin
    fb = ^(r_q & TAPS) ^ ~|r_q[N-2:0];
    r_d = load ? seed : advance ? {r_q[N-2:0], fb} : r_q;
  end
  // State register
  always_ff @(posedge clock or posedge reset)
    if (reset) r_q <= INIT;
    else r_q <= r_d;
  assign r = r_q;
endmodule

// File: rtl/sc_stream_gen.sv
// sc_stream_gen: binary-to-stochastic encoder producing exact-count unipolar bitstreams
module sc_stream_gen import sc_pkg::*; #(
  parameter int N = SC_N,
  parameter int CHANNELS = 4,
  parameter logic [N-1:0] SEED = 'h001,
  parameter logic [N-1:0] TAPS = SC_TAPS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CHANNELS*(N+1)-1:0] in,
  output logic [CHANNELS-1:0]       stream,
  output logic                      valid,
  output logic                      busy,
  output logic                      done
);
  sc_gen_state_t state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d, r;
  logic [CHANNELS-1:0][N:0] hold_q, hold_d;
  logic [CHANNELS-1:0] cmp;
  logic load, advance;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int s);
    logic [2*N-1:0] w;
    w = {x, x} << s;
    return w[2*N-1:N];
  endfunction

  sc_debruijn_lfsr #(.N(N), .TAPS(TAPS), .INIT(SEED)) u_lfsr (
    .clock(clock),
    .reset(reset),
    .load(load),
    .seed(SEED),
    .advance(advance),
    .r(r)
  );

  // Frame sequencing: latch saturated inputs on start, then run exactly 2^N cycles
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    load = 1'b0;
    advance = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        cnt_d = '0;
        load = 1'b1;
        for (int k = 0; k < CHANNELS; k++) hold_d[k] = sat_prob(in[k*(N+1) +: N+1]);
      end
    end else begin
      advance = 1'b1;
      cnt_d = cnt_q + 1'b1;
      state_d = &cnt_q ? IDLE : RUN;
    end
  end

  // State, frame counter and hold registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
    end

  // Per-channel rotated LFSR value against the held probability
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) cmp[k] = {1'b0, rotl(r, k*N/CHANNELS)} < hold_q[k];
  end

  assign valid = state_q == RUN;
  assign busy = valid;
  assign done = valid && &cnt_q;
  assign stream = valid ? cmp : '0;
endmodule

// File: tb/tb_sc_stream_gen.sv
// tb_sc_stream_gen: frame-level model check of three encoders with different seeds
module tb_sc_stream_gen;
  localparam int P = 4096;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [51:0] in = '0;
  logic [2:0][3:0] stream_o;
  logic [2:0] valid_o, busy_o, done_o;
  logic [2:0][11:0] r_o;
  logic [11:0] seq [3][P];
  bit m_run [3];
  int m_cnt [3];
  int m_hold [3][4];
  int ones [3][4];
  int vcnt [3];
  int dcnt [3];
  bit seen [P];
  int n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  sc_stream_gen #(.SEED(12'h001)) u0 (.clock(clock), .reset(reset), .start(start), .in(in),
    .stream(stream_o[0]), .valid(valid_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  sc_stream_gen #(.SEED(12'h000)) u1 (.clock(clock), .reset(reset), .start(start), .in(in),
    .stream(stream_o[1]), .valid(valid_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  sc_stream_gen #(.SEED(12'hABC)) u2 (.clock(clock), .reset(reset), .start(start), .in(in),
    .stream(stream_o[2]), .valid(valid_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  assign r_o[0] = u0.u_lfsr.r;
  assign r_o[1] = u1.u_lfsr.r;
  assign r_o[2] = u2.u_lfsr.r;

  function automatic logic [11:0] nxt(input logic [11:0] r);
    return {r[10:0], ^(r & 12'hE08) ^ (r[10:0] == 11'd0)};
  endfunction

  function automatic int rotl(input logic [11:0] r, input int s);
    int x;
    x = int'(r);
    return ((x << s) | (x >> (12 - s))) & 'hFFF;
  endfunction

  function automatic logic [51:0] pack4(input int a, input int b, input int c, input int d);
    logic [51:0] v;
    v[12:0] = 13'(a);
    v[25:13] = 13'(b);
    v[38:26] = 13'(c);
    v[51:39] = 13'(d);
    return v;
  endfunction

  task automatic check(input string name, input int m, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d: got %0d expected %0d at %0t", name, m, act, exp, $time);
    end
  endtask

  // Reference: each accepted start latches saturated inputs and plays one full frame position by position
  always @(posedge clock or posedge reset) begin
    for (int m = 0; m < 3; m++)
      if (reset) begin
        m_run[m] <= 1'b0;
        m_cnt[m] <= 0;
        for (int k = 0; k < 4; k++) m_hold[m][k] <= 0;
      end else if (!m_run[m]) begin
        if (start) begin
          m_run[m] <= 1'b1;
          m_cnt[m] <= 0;
          for (int k = 0; k < 4; k++)
            m_hold[m][k] <= (int'(in[k*13 +: 13]) > P) ? P : int'(in[k*13 +: 13]);
        end
      end else begin
        m_run[m] <= m_cnt[m] != P - 1;
        m_cnt[m] <= m_cnt[m] + 1;
      end
  end

  // Cycle-by-cycle comparison on the falling edge, plus frame statistics
  always @(negedge clock) begin
    int es;
    if (!reset)
      for (int m = 0; m < 3; m++) begin
        es = 0;
        if (m_run[m])
          for (int k = 0; k < 4; k++)
            if (rotl(seq[m][m_cnt[m]], 3 * k) < m_hold[m][k]) es |= 1 << k;
        check("valid", m, int'(valid_o[m]), int'(m_run[m]));
        check("busy", m, int'(busy_o[m]), int'(m_run[m]));
        check("done", m, int'(done_o[m]), int'(m_run[m] && m_cnt[m] == P - 1));
        check("stream", m, int'(stream_o[m]), es);
        if (m_run[m]) check("lfsr", m, int'(r_o[m]), int'(seq[m][m_cnt[m]]));
        for (int k = 0; k < 4; k++) ones[m][k] += int'(stream_o[m][k]);
        vcnt[m] += int'(valid_o[m]);
        dcnt[m] += int'(done_o[m]);
        if (m == 0 && valid_o[0]) seen[r_o[0]] = 1'b1;
      end
  end

  task automatic begin_frame(input logic [51:0] v, input bit hold);
    for (int m = 0; m < 3; m++) begin
      vcnt[m] = 0;
      dcnt[m] = 0;
      for (int k = 0; k < 4; k++) ones[m][k] = 0;
    end
    for (int i = 0; i < P; i++) seen[i] = 1'b0;
    in = v;
    start = 1'b1;
    @(posedge clock); #1;
    check("start_latency", 0, int'(valid_o[0]), 1);
    if (!hold) start = 1'b0;
  endtask

  task automatic finish_frame(input logic [51:0] e, input int mode);
    int c, nd;
    c = 1;
    while (!done_o[0] && c < 5000) begin
      if (mode == 1) begin
        if (c == 100 || c == 2000) start = 1'b1;
        if (c == 101 || c == 2001) start = 1'b0;
        if (c == 1000) in = ~in;
      end
      @(posedge clock); #1;
      c++;
    end
    check("done_position", 0, c, P);
    @(posedge clock); #1;
    for (int m = 0; m < 3; m++) begin
      check("valid_cycles", m, vcnt[m], P);
      check("done_pulses", m, dcnt[m], 1);
      for (int k = 0; k < 4; k++) check("ones", m, ones[m][k], int'(e[k*13 +: 13]));
    end
    nd = 0;
    for (int i = 0; i < P; i++) nd += int'(seen[i]);
    check("lfsr_distinct", 0, nd, P);
    check("idle_valid", 0, int'(valid_o[0]), 0);
    check("idle_busy", 0, int'(busy_o[0]), 0);
  endtask

  task automatic check_quiet(input string name);
    for (int m = 0; m < 3; m++) begin
      check(name, m, int'({stream_o[m], valid_o[m], busy_o[m], done_o[m]}), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, n_bad=%0d", n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit used [P];
    int nu;
    logic [11:0] r;
    for (int m = 0; m < 3; m++) begin
      r = (m == 0) ? 12'h001 : (m == 1) ? 12'h000 : 12'hABC;
      for (int i = 0; i < P; i++) begin
        seq[m][i] = r;
        r = nxt(r);
      end
    end
    check("model_seq0_4", 0, int'(seq[0][4]), 'h011);
    check("model_seq1_1", 1, int'(seq[1][1]), 'h001);
    check("model_seq2_0", 2, int'(seq[2][0]), 'hABC);
    check("model_rotl", 0, rotl(12'h801, 3), 'h00C);
    for (int i = 0; i < P; i++) used[i] = 1'b0;
    for (int i = 0; i < P; i++) used[seq[0][i]] = 1'b1;
    nu = 0;
    for (int i = 0; i < P; i++) nu += int'(used[i]);
    check("model_distinct", 0, nu, P);
    repeat (3) @(posedge clock);
    #1;
    check_quiet("reset_outputs");
    reset = 1'b0;
    @(posedge clock); #1;
    begin_frame(pack4(0, 0, 0, 0), 1'b0);
    finish_frame(pack4(0, 0, 0, 0), 0);
    begin_frame(pack4(P, P, P, P), 1'b0);
    finish_frame(pack4(P, P, P, P), 0);
    begin_frame(pack4(3, 1024, 2048, 4095), 1'b0);
    finish_frame(pack4(3, 1024, 2048, 4095), 0);
    begin_frame(pack4('h1FFF, 'h1FFF, 'h1FFF, 'h1FFF), 1'b0);
    finish_frame(pack4(P, P, P, P), 1);
    begin_frame(pack4(3, 1024, 2048, 4095), 1'b1);
    finish_frame(pack4(3, 1024, 2048, 4095), 0);
    begin_frame(pack4(P, 0, 2048, 1), 1'b0);
    finish_frame(pack4(P, 0, 2048, 1), 0);
    begin_frame(pack4(3, 1024, 2048, 4095), 1'b0);
    repeat (1499) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_quiet("async_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    begin_frame(pack4(3, 1024, 2048, 4095), 1'b0);
    finish_frame(pack4(3, 1024, 2048, 4095), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sc_stream_gen.md
Name: sc_stream_gen

Overview:
- Binary-to-stochastic encoder: the transmit side of the stochastic-computing datapath.
- Converts CHANNELS binary probabilities (N+1 bits each, so p=1 is representable) into unipolar bitstreams of exactly 2^N cycles per frame.
- Feeds SC filter/arithmetic blocks and the bitstream-to-binary counters downstream.
- Uses a de Bruijn LFSR (every N-bit value exactly once per frame), so the ones-count per channel equals the input value exactly.

Parameters:
- N, 12, binary precision; frame length 2^N.
- CHANNELS, 4, number of parallel streams; N mod CHANNELS = 0 required.
- SEED, 12'h001, LFSR load value at start; any N-bit value is legal, including 0.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only while busy=0.
- in  in  CHANNELS*(N+1)  channel k probability at in[k*(N+1)+:N+1]; legal range 0..2^N; values above 2^N saturate to 2^N.
- stream  out  CHANNELS  stochastic bit per channel, bit k = channel k.
- valid  out  1  stream bits are meaningful this cycle.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse coincident with the last valid bit of a frame.

Behaviour:
- Reset (async, any state including mid-frame): FSM=IDLE; stream=0, valid=0, busy=0, done=0; LFSR=SEED; frame counter=0; latched inputs=0.
- FSM states: IDLE, RUN.
- IDLE: busy=0, valid=0, stream=0.
- IDLE with start=1 at edge t: latch all channel inputs (saturated) into hold registers, load LFSR R=SEED, clear counter, go to RUN.
- Start latency: first valid bit appears in the cycle after edge t.
- RUN: valid=1 and busy=1 for exactly 2^N consecutive cycles.
- RUN per cycle: stream[k] = (rotl(R, k*N/CHANNELS) < hold_k), unsigned compare of the N-bit value zero-extended to N+1 bits. R then advances and the counter increments.
- RUN end: done=1 in the cycle where counter = 2^N-1. The next edge returns to IDLE, giving at least one idle cycle between frames.
- start while busy=1: ignored, no queuing.
- start held high: a new frame begins after the one IDLE cycle.
- in changes during RUN: no effect (hold registers only).
- LFSR: Fibonacci, left shift. Feedback = XOR of taps at positions TAPS, XOR NOR(R[N-2:0]). This zero-inserting de Bruijn form visits all 2^N states, period 2^N, from any seed.
- Exactness: rotation is a bijection, so each channel sees each N-bit value once per frame. Ones per channel = hold_k exactly.
  - hold=0 gives an all-zero stream.
  - hold=2^N gives an all-one stream.
- Channel rotations decorrelate streams for SC multiplication downstream.
- Outputs registered: stream, valid and done come from flops, not from combinational paths on in or start.

Decomposition:
- Package sc_pkg:
  - SC_N=12, SC_POW2N=4096.
  - Tap mask constant for N=12: taps 12,11,10,4 (x^12+x^11+x^10+x^4+1).
  - typedef enum {IDLE, RUN} sc_gen_state_t.
  - Function sat_prob() clamps to 2^N.
- Sub-module sc_debruijn_lfsr:
  - Parameters N, TAPS.
  - Ports clock, reset, load, seed, advance, r[N-1:0].
  - Shared with future SNG users.
- Top-level sc_stream_gen holds the FSM, counter, hold registers and CHANNELS comparators.

Test Plan:
- Exact count: all channels in=0, frame -> 0 ones per channel. All channels in=4096 -> 4096 ones each. Both cases: valid high exactly 4096 cycles, done exactly one cycle on the last.
- Mixed values: in = {3, 1024, 2048, 4095} per channel -> counted ones exactly 3, 1024, 2048, 4095. Repeat with SEED=0 and SEED=12'hABC -> same counts.
- Saturation and hold: in=13'h1FFF -> 4096 ones. Change in mid-frame -> counts still match the values latched at start.
- Handshake: first valid one cycle after the start edge. Pulse start at cycles 100 and 2000 of a frame -> ignored. start held high -> next frame begins after exactly one IDLE cycle.
- Async reset mid-frame at cycle 1500: all outputs 0 immediately, before the next clock edge. Following start -> a full 4096-cycle frame with correct counts.
- LFSR coverage: bench monitors sc_debruijn_lfsr.r over one frame -> 4096 distinct values. Channel 1 sequence equals channel 0 rotated left by 3.
